conv_expand_engine: RTL and testbench
=====================================

CONV_EXPAND_ENGINE -- requirements
Module: conv_expand_engine

Interface
REQ-001 SHALL have parameter DSP_NO, default 192, number of parallel output channels (MAC lanes).
REQ-002 SHALL have parameter WIDTH, default 16, signed fixed-point width of pixels, weights, biases and outputs.
REQ-003 SHALL have parameter CHIN, default 64, input channels per window.
REQ-004 SHALL have parameter KERNEL_DIM, default 3, square kernel side; TAPS = CHIN*KERNEL_DIM**2.
REQ-005 SHALL have parameter NWIN, default 256, windows (output pixels) per layer run.
REQ-006 SHALL have parameter FRAC, default 8, fractional bits; output = accumulator >> FRAC.
REQ-007 SHALL have parameter RELU_EN, default 1, 1 = clamp negatives to 0.
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 reset.
REQ-009 SHALL have ports: start in 1 run request; busy out 1 run active; done out 1 one-cycle end-of-run pulse.
REQ-010 SHALL have ports: ifm in WIDTH pixel; ifm_valid in 1 pixel strobe; ifm_ready out 1 pixel accept.
REQ-011 SHALL have ports: w_addr out clog2(TAPS) tap index; w_data in DSP_NO*WIDTH weights for w_addr, combinational same cycle.
REQ-012 SHALL have ports: bias in DSP_NO*WIDTH per-lane bias, static during a run.
REQ-013 SHALL have ports: ofm out DSP_NO*WIDTH results; ofm_valid out 1 one-cycle result strobe.
REQ-014 SHALL use one clock; reset is synchronous and active-high (clk, rst).

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN after last tap of window NWIN-1 accepted; DRAIN -> IDLE after final ofm_valid, asserting done that cycle.
REQ-016 SHALL ignore start while busy; busy = state != IDLE.
REQ-017 SHALL assert ifm_ready only in RUN; a tap is accepted when ifm_valid && ifm_ready.
REQ-018 SHALL drive w_addr = current tap index; index advances only on accepted tap, wraps TAPS-1 -> 0; holds on stall.
REQ-019 SHALL compute per lane signed product ifm*w_data[lane] (2*WIDTH) and accumulate in ACC_W = 2*WIDTH+clog2(TAPS) bits, no overflow.
REQ-020 SHALL load (not add) the accumulator on tap 0 of each window, so consecutive windows need no bubble cycle.
REQ-021 SHALL, when tap TAPS-1 is accepted at cycle t, present ofm with ofm_valid at t+2 (accumulate register, then output register).
REQ-022 SHALL compute output = (acc + (sign-extended bias << FRAC)) >>> FRAC, saturated to signed WIDTH range, then ReLU if RELU_EN.
REQ-023 SHALL hold ofm stable between ofm_valid pulses; ofm_valid asserts exactly NWIN times per run.
REQ-024 SHALL neither accumulate nor advance counters on a stall cycle (ifm_valid low).
REQ-025 SHALL allow a new start in the cycle after done.

Reset
REQ-026 SHALL, on rst high at a clock edge, force IDLE, tap/window counters 0, accumulators 0, ofm 0, ofm_valid 0, done 0, busy 0, ifm_ready 0.
REQ-027 SHALL abort a run on mid-operation reset with no further ofm_valid or done.
REQ-028 SHALL give rst priority over start in the same cycle.

Structure
REQ-029 SHALL take FSM state enum and ACC_W/TAPS helper functions from shared package cnn_pkg.
REQ-030 SHALL use one sub-module mac_lane (multiply, load/accumulate, bias, shift, saturate, ReLU), instantiated DSP_NO times.

Verification
REQ-031 SHALL test DSP_NO=4, CHIN=1, KERNEL_DIM=3, NWIN=2, all pixels 1.0 (256), weights 1.0, bias 0 -> two ofm_valid, each lane 2304 (9.0).
REQ-032 SHALL test one lane weights -1.0, bias 0, RELU_EN=1 -> that lane 0; RELU_EN=0 -> -2304.
REQ-033 SHALL test pixels and weights 0x7FFF, TAPS=9 -> ofm saturates to 0x7FFF.
REQ-034 SHALL test ifm_valid toggling every other cycle -> results identical to no-stall run; ofm_valid 2 cycles after last accepted tap.
REQ-035 SHALL test rst asserted mid-window 1 -> all outputs 0 next cycle, no done; fresh start then yields correct results.
REQ-036 SHALL test start pulsed while busy -> ignored; exactly NWIN ofm_valid and one done.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the convolution engines.
// Window/tap geometry and accumulator width are derived here.
package cnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  function automatic int taps_f(input int chin, input int k);
    return chin * k * k;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_w_f(input int width, input int taps);
    return 2 * width + $clog2(taps);
  endfunction

endpackage

// File: rtl/conv_expand_engine_if.sv
// Pixel stream in, per-lane result bundle out.
// The engine takes the slave side of this interface.
interface conv_expand_engine_if #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 192
);
  logic [WIDTH-1:0]        ifm;
  logic                    ifm_valid;
  logic                    ifm_ready;
  logic [DSP_NO*WIDTH-1:0] ofm;
  logic                    ofm_valid;

  modport master (
    output ifm, ifm_valid,
    input  ifm_ready, ofm, ofm_valid
  );

  modport slave (
    input  ifm, ifm_valid,
    output ifm_ready, ofm, ofm_valid
  );
endinterface

// File: rtl/mac_lane.sv
// One MAC lane: multiply, load/accumulate, then bias,
// scale, saturate and optional ReLU into an output register.
module mac_lane #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int RELU_EN = 1,
  parameter int ACC_W   = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    first,
  input  logic                    fire,
  input  logic signed [WIDTH-1:0] ifm,
  input  logic signed [WIDTH-1:0] w,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] ofm
);
  localparam int SUM_W =
    ((ACC_W > WIDTH + FRAC) ? ACC_W : WIDTH + FRAC) + 1;
  localparam logic signed [SUM_W-1:0] MAXV =
    SUM_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MINV = -MAXV - 1;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_x;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shr;
  logic signed [WIDTH-1:0]   res;

  assign prod   = ifm * w;
  assign prod_x = ACC_W'(prod);

  always_comb begin
    sum = SUM_W'(acc_q) + (SUM_W'(bias) <<< FRAC);
    shr = sum >>> FRAC;
    if (shr > MAXV) begin
      res = MAXV[WIDTH-1:0];
    end else if (shr < MINV) begin
      res = MINV[WIDTH-1:0];
    end else begin
      res = shr[WIDTH-1:0];
    end
    if (RELU_EN != 0 && res[WIDTH-1]) begin
      res = '0;
    end
  end

  // Tap 0 loads rather than adds, so windows run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= first ? prod_x : acc_q + prod_x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ofm <= '0;
    end else if (fire) begin
      ofm <= res;
    end
  end
endmodule

// File: rtl/conv_expand_engine.sv
// Streams NWIN windows of TAPS pixels through DSP_NO MAC lanes,
// emitting one result vector per window.
module conv_expand_engine
  import cnn_pkg::*;
#(
  parameter int DSP_NO     = 192,
  parameter int WIDTH      = 16,
  parameter int CHIN       = 64,
  parameter int KERNEL_DIM = 3,
  parameter int NWIN       = 256,
  parameter int FRAC       = 8,
  parameter int RELU_EN    = 1,
  localparam int TAPS  = taps_f(CHIN, KERNEL_DIM),
  localparam int AW    = clog2_min1(TAPS),
  localparam int WW    = clog2_min1(NWIN),
  localparam int ACC_W = acc_w_f(WIDTH, TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  conv_expand_engine_if.slave     io,
  output logic [AW-1:0]           w_addr,
  input  logic [DSP_NO*WIDTH-1:0] w_data,
  input  logic [DSP_NO*WIDTH-1:0] bias
);
  localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(NWIN - 1);

  state_t                  state_q, state_d;
  logic [AW-1:0]           tap_q;
  logic [WW-1:0]           win_q;
  logic                    accept, tap_end, run_end;
  logic                    last_q, valid_q, done_q;
  logic [DSP_NO*WIDTH-1:0] ofm_w;

  assign accept  = io.ifm_valid && io.ifm_ready;
  assign tap_end = accept && (tap_q == TAP_LAST);
  assign run_end = tap_end && (win_q == WIN_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (run_end) state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      win_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tap_q <= tap_end ? '0 : tap_q + 1'b1;
        if (tap_end) begin
          win_q <= run_end ? '0 : win_q + 1'b1;
        end
      end
      // Result lands one cycle after the accumulator settles.
      last_q  <= tap_end;
      valid_q <= last_q;
      done_q  <= (state_q == S_DRAIN);
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign w_addr       = tap_q;
  assign io.ifm_ready = (state_q == S_RUN);
  assign io.ofm_valid = valid_q;
  assign io.ofm       = ofm_w;

  for (genvar l = 0; l < DSP_NO; l++) begin : g_lane
    mac_lane #(
      .WIDTH   (WIDTH),
      .FRAC    (FRAC),
      .RELU_EN (RELU_EN),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (accept),
      .first (tap_q == '0),
      .fire  (last_q),
      .ifm   (io.ifm),
      .w     (w_data[l*WIDTH +: WIDTH]),
      .bias  (bias[l*WIDTH +: WIDTH]),
      .ofm   (ofm_w[l*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_conv_expand_engine.sv
// Bench for conv_expand_engine: two instances (ReLU on/off) driven
// together and checked against an arithmetic window model.
module tb_conv_expand_engine;
  localparam int L = 4;
  localparam int W = 16;
  localparam int T = 9;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst, start;
  logic busy0, busy1, done0, done1;
  logic [3:0] wa0, wa1;
  logic [L*W-1:0] wd0, wd1, bias_bus;
  logic [W-1:0] ifm;
  logic ifm_valid;

  logic signed [W-1:0] px   [N][T];
  logic signed [W-1:0] wmem [L][16];
  logic signed [W-1:0] biasv[L];

  int checks = 0;
  int errors = 0;

  conv_expand_engine_if #(.WIDTH(W), .DSP_NO(L)) io0 ();
  conv_expand_engine_if #(.WIDTH(W), .DSP_NO(L)) io1 ();

  assign io0.ifm       = ifm;
  assign io1.ifm       = ifm;
  assign io0.ifm_valid = ifm_valid;
  assign io1.ifm_valid = ifm_valid;

  always #5 clk = ~clk;

  always_comb begin
    wd0 = '0;
    wd1 = '0;
    bias_bus = '0;
    for (int l = 0; l < L; l++) begin
      wd0[l*W +: W]      = wmem[l][wa0];
      wd1[l*W +: W]      = wmem[l][wa1];
      bias_bus[l*W +: W] = biasv[l];
    end
  end

  conv_expand_engine #(
    .DSP_NO(L), .WIDTH(W), .CHIN(1), .KERNEL_DIM(3),
    .NWIN(N), .FRAC(8), .RELU_EN(1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0),
    .done(done0), .io(io0), .w_addr(wa0), .w_data(wd0),
    .bias(bias_bus)
  );

  conv_expand_engine #(
    .DSP_NO(L), .WIDTH(W), .CHIN(1), .KERNEL_DIM(3),
    .NWIN(N), .FRAC(8), .RELU_EN(0)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1),
    .done(done1), .io(io1), .w_addr(wa1), .w_data(wd1),
    .bias(bias_bus)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window result from plain dot-product arithmetic.
  function automatic longint model(input int win, input int lane,
                                   input bit relu);
    longint acc = 0;
    for (int t = 0; t < T; t++)
      acc += longint'(px[win][t]) * longint'(wmem[lane][t]);
    acc += longint'(biasv[lane]) * 256;
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic fill(input int p, input int wv, input int b);
    for (int n = 0; n < N; n++)
      for (int t = 0; t < T; t++) px[n][t] = W'(p);
    for (int l = 0; l < L; l++) begin
      for (int t = 0; t < 16; t++) wmem[l][t] = W'(wv);
      biasv[l] = W'(b);
    end
  endtask

  task automatic fill_rand();
    for (int n = 0; n < N; n++)
      for (int t = 0; t < T; t++)
        px[n][t] = W'(int'($urandom_range(0, 1023)) - 512);
    for (int l = 0; l < L; l++) begin
      for (int t = 0; t < 16; t++)
        wmem[l][t] = W'(int'($urandom_range(0, 1023)) - 512);
      biasv[l] = W'(int'($urandom_range(0, 4095)) - 2048);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy0"}, busy0, 0);
    chk({tag, " busy1"}, busy1, 0);
    chk({tag, " done0"}, done0, 0);
    chk({tag, " ready0"}, io0.ifm_ready, 0);
    chk({tag, " ready1"}, io1.ifm_ready, 0);
    chk({tag, " ovalid0"}, io0.ofm_valid, 0);
    chk({tag, " ofm0"}, io0.ofm, 0);
    chk({tag, " ofm1"}, io1.ofm, 0);
    chk({tag, " waddr0"}, wa0, 0);
  endtask

  task automatic run_case(input string tag, input bit stall,
                          input int start_at, input int abort_at);
    int idx, nv, nd, post, bad;
    int lastc[N];
    bit acc;
    idx = 0; nv = 0; nd = 0; post = 0; bad = 0;
    lastc[0] = 0; lastc[1] = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        ifm_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset({tag, " abort"});
        repeat (4) begin
          @(posedge clk); #1;
          if (io0.ofm_valid || done0 || done1) bad++;
        end
        chk({tag, " no output after abort"}, bad, 0);
        return;
      end
      ifm_valid = (idx < N*T) && (!stall || (k % 2 == 1));
      ifm = (idx < N*T) ? px[idx/T][idx%T] : '0;
      start = (k == start_at);
      acc = ifm_valid && io0.ifm_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        if (idx % T == T-1) lastc[idx/T] = k;
        idx++;
      end
      if (io0.ofm_valid || io1.ofm_valid)
        chk($sformatf("%s valid1", tag), io1.ofm_valid, io0.ofm_valid);
      if (io0.ofm_valid) begin
        if (nv < N) begin
          chk($sformatf("%s latency w%0d", tag, nv), k + 1 - lastc[nv], 2);
          for (int l = 0; l < L; l++) begin
            chk($sformatf("%s w%0d lane%0d relu", tag, nv, l),
                $signed(io0.ofm[l*W +: W]), model(nv, l, 1));
            chk($sformatf("%s w%0d lane%0d raw", tag, nv, l),
                $signed(io1.ofm[l*W +: W]), model(nv, l, 0));
          end
        end
        nv++;
      end
      if (done0) begin
        nd++;
        chk({tag, " done with last valid"}, nv, N);
      end
      if (nd > 0) begin
        post++;
        if (post > 3) break;
      end
    end
    ifm_valid = 1'b0;
    chk({tag, " valid count"}, nv, N);
    chk({tag, " done count"}, nd, 1);
    chk({tag, " idle after"}, busy0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ifm = '0;
    ifm_valid = 1'b0;
    fill(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst beats start", busy0, 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    fill(256, 256, 0);
    run_case("unity", 0, -1, -1);

    fill(256, 256, 0);
    for (int t = 0; t < 16; t++) wmem[2][t] = -16'sd256;
    run_case("neg lane", 0, -1, -1);

    fill(32767, 32767, 0);
    run_case("saturate", 0, -1, -1);

    fill_rand();
    run_case("rand nostall", 0, -1, -1);
    run_case("rand stall", 1, -1, -1);

    fill_rand();
    run_case("start busy", 0, 4, -1);

    fill_rand();
    run_case("abort", 0, -1, T + 3);
    run_case("after abort", 0, -1, -1);

    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run_case($sformatf("rand%0d", r), r % 2, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
